// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/load-store memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic {OWN_INST, OWN_DATA} owner_t;

   localparam int unsigned GNT_I = 0;
   localparam int unsigned GNT_D = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle of mem_arbiter; slave is the arbiter's view.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              i_req_valid;
   logic [ADDR_W-1:0] i_req_addr;
   logic              i_req_ready;
   logic              i_resp_valid;
   logic [DATA_W-1:0] i_resp_data;

   logic              d_req_valid;
   logic [ADDR_W-1:0] d_req_addr;
   logic              d_req_we;
   logic [DATA_W-1:0] d_req_wdata;
   logic              d_req_ready;
   logic              d_resp_valid;
   logic [DATA_W-1:0] d_resp_data;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_we, d_req_wdata, mem_rdata,
      output i_req_ready, i_resp_valid, i_resp_data, d_req_ready, d_resp_valid, d_resp_data,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_we, d_req_wdata, mem_rdata,
      input  i_req_ready, i_resp_valid, i_resp_data, d_req_ready, d_resp_valid, d_resp_data,
             mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and load/store requests.
// MEM_ARB_RR_EN: round-robin on ties using last_grant; otherwise data beats fetch.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic       idle,
   input  logic       i_valid,
   input  logic       d_valid,
`ifdef MEM_ARB_RR_EN
   input  owner_t     last_grant,
`endif
   output logic [1:0] grant,
   output owner_t     owner
);

   logic d_wins;

`ifdef MEM_ARB_RR_EN
   // On a tie the port that did not win last time goes first
   assign d_wins = d_valid && !(i_valid && (last_grant == OWN_DATA));
`else
   assign d_wins = d_valid;
`endif

   always_comb begin
      grant = 2'b00;
      owner = OWN_INST;
      if (idle) begin
         if (d_wins) begin
            grant[GNT_D] = 1'b1;
            owner        = OWN_DATA;
         end else if (i_valid) begin
            grant[GNT_I] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed data-over-fetch priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);

   localparam int unsigned      CNT_W    = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT);

   state_t            state, state_nxt;
   owner_t            owner, owner_nxt, pick_owner;
   logic [1:0]        grant;
   logic              idle;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              we_q, we_nxt;
   logic              mem_en, mem_en_nxt;
   logic              mem_we, mem_we_nxt;
   logic [ADDR_W-1:0] mem_addr, mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata, mem_wdata_nxt;
   logic              i_resp_valid, i_resp_valid_nxt;
   logic [DATA_W-1:0] i_resp_data, i_resp_data_nxt;
   logic              d_resp_valid, d_resp_valid_nxt;
   logic [DATA_W-1:0] d_resp_data, d_resp_data_nxt;

   // Ready is suppressed while reset is asserted so every output reads 0
   assign idle = (state == IDLE) && rst_n;

`ifdef MEM_ARB_RR_EN
   owner_t last_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      last_grant <= OWN_INST;
      else if (|grant) last_grant <= pick_owner;
   end
`endif

   mem_arb_pick u_pick (
      .idle       (idle),
      .i_valid    (bus.i_req_valid),
      .d_valid    (bus.d_req_valid),
`ifdef MEM_ARB_RR_EN
      .last_grant (last_grant),
`endif
      .grant      (grant),
      .owner      (pick_owner)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|grant) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (cnt == CNT_LAST) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs and transaction context
   always_comb begin
      owner_nxt        = owner;
      cnt_nxt          = cnt;
      we_nxt           = we_q;
      mem_en_nxt       = 1'b0;
      mem_we_nxt       = 1'b0;
      mem_addr_nxt     = mem_addr;
      mem_wdata_nxt    = mem_wdata;
      i_resp_valid_nxt = 1'b0;
      i_resp_data_nxt  = i_resp_data;
      d_resp_valid_nxt = 1'b0;
      d_resp_data_nxt  = d_resp_data;
      case (state)
         IDLE: begin
            if (|grant) begin
               owner_nxt  = pick_owner;
               mem_en_nxt = 1'b1;
               if (grant[GNT_D]) begin
                  mem_addr_nxt  = bus.d_req_addr;
                  mem_wdata_nxt = bus.d_req_wdata;
                  we_nxt        = bus.d_req_we;
                  mem_we_nxt    = bus.d_req_we;
               end else begin
                  mem_addr_nxt  = bus.i_req_addr;
                  we_nxt        = 1'b0;
               end
            end
         end
         ISSUE: cnt_nxt = CNT_W'(1);
         WAIT: begin
            if (cnt == CNT_LAST) begin
               if (owner == OWN_DATA) begin
                  d_resp_valid_nxt = 1'b1;
                  d_resp_data_nxt  = we_q ? '0 : bus.mem_rdata;
               end else begin
                  i_resp_valid_nxt = 1'b1;
                  i_resp_data_nxt  = bus.mem_rdata;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner        <= OWN_INST;
         cnt          <= '0;
         we_q         <= 1'b0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         i_resp_valid <= 1'b0;
         i_resp_data  <= '0;
         d_resp_valid <= 1'b0;
         d_resp_data  <= '0;
      end else begin
         owner        <= owner_nxt;
         cnt          <= cnt_nxt;
         we_q         <= we_nxt;
         mem_en       <= mem_en_nxt;
         mem_we       <= mem_we_nxt;
         mem_addr     <= mem_addr_nxt;
         mem_wdata    <= mem_wdata_nxt;
         i_resp_valid <= i_resp_valid_nxt;
         i_resp_data  <= i_resp_data_nxt;
         d_resp_valid <= d_resp_valid_nxt;
         d_resp_data  <= d_resp_data_nxt;
      end
   end

   assign bus.i_req_ready  = grant[GNT_I];
   assign bus.d_req_ready  = grant[GNT_D];
   assign bus.i_resp_valid = i_resp_valid;
   assign bus.i_resp_data  = i_resp_data;
   assign bus.d_resp_valid = d_resp_valid;
   assign bus.d_resp_data  = d_resp_data;
   assign bus.mem_en       = mem_en;
   assign bus.mem_we       = mem_we;
   assign bus.mem_addr     = mem_addr;
   assign bus.mem_wdata    = mem_wdata;

endmodule
